// File: rtl/x_ramb_pkg.sv
// Shared types and helpers for the parametrised true dual-port RAM.
// Optional output register stage is selected with `define X_RAMB_DOREG_EN.
package x_ramb_pkg;

  typedef enum logic [1:0] {
    WRITE_FIRST = 2'b00,
    READ_FIRST  = 2'b01,
    NO_CHANGE   = 2'b10
  } wr_mode_t;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } clr_state_t;

  localparam int         MODE_STR_W = 88;
  localparam logic [1:0] MODE_BAD   = 2'b11;

  function automatic int be_width(input int data_w);
    return (data_w + 7) / 8;
  endfunction

  // Unknown strings map to MODE_BAD so the top can stop elaboration.
  function automatic logic [1:0] mode_of(input logic [MODE_STR_W-1:0] s);
    if (s == MODE_STR_W'("WRITE_FIRST")) return WRITE_FIRST;
    if (s == MODE_STR_W'("READ_FIRST"))  return READ_FIRST;
    if (s == MODE_STR_W'("NO_CHANGE"))   return NO_CHANGE;
    return MODE_BAD;
  endfunction

endpackage

// File: rtl/x_ramb_tdp_param_port_out.sv
// Per-port lane merge and write-mode read-data selection.
// With X_RAMB_DOREG_EN defined a second output register adds one cycle of latency.
module x_ramb_port_out
  import x_ramb_pkg::*;
#(
  parameter int               DATA_W = 16,
  parameter int               BE_W   = 2,
  parameter wr_mode_t         MODE   = WRITE_FIRST,
  parameter logic [DATA_W-1:0] SRVAL = '0
) (
  input  logic              clk_i,
  input  logic              ssr_i,
  input  logic              act_i,
  input  logic [BE_W-1:0]   we_i,
  input  logic [DATA_W-1:0] old_i,
  input  logic [DATA_W-1:0] din_i,
  output logic [DATA_W-1:0] wmask_o,
  output logic [DATA_W-1:0] merged_o,
  output logic [DATA_W-1:0] do_o
);

  logic [DATA_W-1:0] do1_q, do1_d;

  for (genvar i = 0; i < DATA_W; i++) begin : g_mask
    assign wmask_o[i] = act_i & we_i[i/8];
  end

  assign merged_o = (old_i & ~wmask_o) | (din_i & wmask_o);

  always_comb begin
    do1_d = do1_q;
    if (act_i) begin
      case (MODE)
        WRITE_FIRST: do1_d = merged_o;
        READ_FIRST:  do1_d = old_i;
        NO_CHANGE:   if (!(|we_i)) do1_d = old_i;
        default:     do1_d = do1_q;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (ssr_i) do1_q <= SRVAL;
    else       do1_q <= do1_d;
  end

`ifdef X_RAMB_DOREG_EN
  logic [DATA_W-1:0] do2_q;

  always_ff @(posedge clk_i) begin
    if (ssr_i) do2_q <= SRVAL;
    else       do2_q <= do1_q;
  end

  assign do_o = do2_q;
`else
  assign do_o = do1_q;
`endif

endmodule

// File: rtl/x_ramb_tdp_param.sv
// Parametrised true dual-port block RAM with byte enables, collision flag and
// post-reset clear sequencer. X_RAMB_DOREG_EN adds an output register per port.
module x_ramb_tdp_param
  import x_ramb_pkg::*;
#(
  parameter int                    DATA_W         = 16,
  parameter int                    ADDR_W         = 4,
  parameter int                    BE_W           = be_width(DATA_W),
  parameter logic [MODE_STR_W-1:0] WRITE_MODE_A   = MODE_STR_W'("WRITE_FIRST"),
  parameter logic [MODE_STR_W-1:0] WRITE_MODE_B   = MODE_STR_W'("WRITE_FIRST"),
  parameter logic [DATA_W-1:0]     SRVAL_A        = '0,
  parameter logic [DATA_W-1:0]     SRVAL_B        = '0,
  parameter logic [DATA_W-1:0]     INIT_VAL       = '0,
  parameter bit                    CLEAR_ON_RESET = 1'b1
) (
  input  logic              CLK,
  input  logic              SSR,
  input  logic              ENA,
  input  logic [BE_W-1:0]   WEA,
  input  logic [ADDR_W-1:0] ADDRA,
  input  logic [DATA_W-1:0] DIA,
  output logic [DATA_W-1:0] DOA,
  input  logic              ENB,
  input  logic [BE_W-1:0]   WEB,
  input  logic [ADDR_W-1:0] ADDRB,
  input  logic [DATA_W-1:0] DIB,
  output logic [DATA_W-1:0] DOB,
  output logic              BUSY,
  output logic              COLLISION
);

  localparam int          DEPTH    = 1 << ADDR_W;
  localparam logic [1:0]  MODE_A_R = mode_of(WRITE_MODE_A);
  localparam logic [1:0]  MODE_B_R = mode_of(WRITE_MODE_B);

  if (MODE_A_R == MODE_BAD) begin : g_bad_mode_a
    $fatal(1, "x_ramb_tdp_param: illegal WRITE_MODE_A");
  end
  if (MODE_B_R == MODE_BAD) begin : g_bad_mode_b
    $fatal(1, "x_ramb_tdp_param: illegal WRITE_MODE_B");
  end

  logic [DATA_W-1:0] mem_q [DEPTH];

  clr_state_t        state_q, state_d;
  logic [ADDR_W-1:0] clr_ptr_q, clr_ptr_d;
  logic              busy, clr_we;
  logic              coll_q;

  logic [DATA_W-1:0] old_a, old_b, wmask_a, wmask_b, merged_a, merged_b, b_word;
  logic              act_a, act_b;

  // Clear sequencer: state register / next state / outputs.
  always_ff @(posedge CLK) begin
    if (SSR) begin
      state_q   <= CLEAR_ON_RESET ? CLEAR : IDLE;
      clr_ptr_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_ptr_q <= clr_ptr_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    clr_ptr_d = clr_ptr_q;
    if (state_q == CLEAR) begin
      clr_ptr_d = clr_ptr_q + 1'b1;
      if (clr_ptr_q == ADDR_W'(DEPTH - 1)) state_d = IDLE;
    end
  end

  always_comb begin
    busy   = (state_q == CLEAR);
    clr_we = busy & ~SSR;
  end

  assign BUSY  = busy;
  assign act_a = ENA & ~busy;
  assign act_b = ENB & ~busy;
  assign old_a = mem_q[ADDRA];
  assign old_b = mem_q[ADDRB];

  x_ramb_port_out #(
    .DATA_W (DATA_W),
    .BE_W   (BE_W),
    .MODE   (wr_mode_t'(MODE_A_R)),
    .SRVAL  (SRVAL_A)
  ) u_port_a (
    .clk_i    (CLK),
    .ssr_i    (SSR),
    .act_i    (act_a),
    .we_i     (WEA),
    .old_i    (old_a),
    .din_i    (DIA),
    .wmask_o  (wmask_a),
    .merged_o (merged_a),
    .do_o     (DOA)
  );

  x_ramb_port_out #(
    .DATA_W (DATA_W),
    .BE_W   (BE_W),
    .MODE   (wr_mode_t'(MODE_B_R)),
    .SRVAL  (SRVAL_B)
  ) u_port_b (
    .clk_i    (CLK),
    .ssr_i    (SSR),
    .act_i    (act_b),
    .we_i     (WEB),
    .old_i    (old_b),
    .din_i    (DIB),
    .wmask_o  (wmask_b),
    .merged_o (merged_b),
    .do_o     (DOB)
  );

  // Same-address double write: B's lanes land on top of A's merged word.
  assign b_word = (ADDRA == ADDRB && (|wmask_a))
                ? ((merged_a & ~wmask_b) | (DIB & wmask_b))
                : merged_b;

  always_ff @(posedge CLK) begin
    if (clr_we) begin
      mem_q[clr_ptr_q] <= INIT_VAL;
    end else if (!SSR && !busy) begin
      if (|wmask_a) mem_q[ADDRA] <= merged_a;
      if (|wmask_b) mem_q[ADDRB] <= b_word;
    end
  end

  always_ff @(posedge CLK) begin
    if (SSR) coll_q <= 1'b0;
    else     coll_q <= ~busy & ENA & ENB & (ADDRA == ADDRB) & ((|WEA) | (|WEB));
  end

  assign COLLISION = coll_q;

endmodule

// File: tb/tb_x_ramb_tdp_param.sv
// Directed + randomized bench for x_ramb_tdp_param against a lane-level array model.
// Port A is WRITE_FIRST, port B is READ_FIRST.
module tb_x_ramb_tdp_param;

  localparam int          DEPTH = 16;
  localparam logic [15:0] SRA   = 16'hA5A5;
  localparam logic [15:0] SRB   = 16'h5A5A;
  localparam logic [15:0] INITV = 16'h0000;
  localparam int          MA    = 0;  // 0 = write-first, 1 = read-first, 2 = no-change
  localparam int          MB    = 1;

  logic        CLK = 1'b0;
  logic        SSR = 1'b0, ENA = 1'b0, ENB = 1'b0;
  logic [1:0]  WEA = '0, WEB = '0;
  logic [3:0]  ADDRA = '0, ADDRB = '0;
  logic [15:0] DIA = '0, DIB = '0;
  logic [15:0] DOA, DOB;
  logic        BUSY, COLLISION;

  int tests = 0;
  int fails = 0;

  logic [15:0] m_mem [DEPTH];
  logic [15:0] m_do1a, m_do1b, m_oa, m_ob;
  bit          m_busy, m_coll;
  int          m_ptr;

  always #5 CLK = ~CLK;

  x_ramb_tdp_param #(
    .DATA_W         (16),
    .ADDR_W         (4),
    .WRITE_MODE_A   (88'("WRITE_FIRST")),
    .WRITE_MODE_B   (88'("READ_FIRST")),
    .SRVAL_A        (SRA),
    .SRVAL_B        (SRB),
    .INIT_VAL       (INITV),
    .CLEAR_ON_RESET (1'b1)
  ) dut (
    .CLK(CLK), .SSR(SSR),
    .ENA(ENA), .WEA(WEA), .ADDRA(ADDRA), .DIA(DIA), .DOA(DOA),
    .ENB(ENB), .WEB(WEB), .ADDRB(ADDRB), .DIB(DIB), .DOB(DOB),
    .BUSY(BUSY), .COLLISION(COLLISION)
  );

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] want);
    tests++;
    assert (got === want) else begin
      fails++;
      $error("FAIL %s got=%h want=%h", tag, got, want);
    end
  endtask

  function automatic logic [15:0] do_sel(input int mode, input logic [15:0] cur,
                                         input logic [15:0] old, input logic [15:0] nw,
                                         input logic [1:0] we);
    if (mode == 0) return nw;
    if (mode == 1) return old;
    return (we != 2'b00) ? cur : old;
  endfunction

  // Apply one clock of stimulus, advance the model, then compare every output.
  task automatic step(input string tag, input logic rst,
                      input logic ea, input logic [1:0] wa, input logic [3:0] aa, input logic [15:0] da,
                      input logic eb, input logic [1:0] wb, input logic [3:0] ab, input logic [15:0] db);
    logic [15:0] oa, ob, na, nb, p1a, p1b;
    SSR = rst; ENA = ea; WEA = wa; ADDRA = aa; DIA = da;
    ENB = eb; WEB = wb; ADDRB = ab; DIB = db;
    p1a = m_do1a; p1b = m_do1b;
    if (rst) begin
      m_do1a = SRA; m_do1b = SRB; m_coll = 0; m_busy = 1; m_ptr = 0;
    end else if (m_busy) begin
      m_mem[m_ptr] = INITV;
      if (m_ptr == DEPTH - 1) m_busy = 0;
      m_ptr++;
      m_coll = 0;
    end else begin
      oa = m_mem[aa]; ob = m_mem[ab];
      na = oa; nb = ob;
      for (int l = 0; l < 2; l++) begin
        if (ea && wa[l]) na[l*8 +: 8] = da[l*8 +: 8];
        if (eb && wb[l]) nb[l*8 +: 8] = db[l*8 +: 8];
      end
      if (ea) m_mem[aa] = na;
      for (int l = 0; l < 2; l++)
        if (eb && wb[l]) m_mem[ab][l*8 +: 8] = db[l*8 +: 8];
      if (ea) m_do1a = do_sel(MA, m_do1a, oa, na, wa);
      if (eb) m_do1b = do_sel(MB, m_do1b, ob, nb, wb);
      m_coll = ea && eb && (aa == ab) && (wa != 2'b00 || wb != 2'b00);
    end
`ifdef X_RAMB_DOREG_EN
    m_oa = rst ? SRA : p1a;
    m_ob = rst ? SRB : p1b;
`else
    m_oa = m_do1a;
    m_ob = m_do1b;
`endif
    @(posedge CLK);
    #1;
    chk({tag, ".doa"}, DOA, m_oa);
    chk({tag, ".dob"}, DOB, m_ob);
    chk({tag, ".coll"}, {15'b0, COLLISION}, {15'b0, m_coll});
    chk({tag, ".busy"}, {15'b0, BUSY}, {15'b0, m_busy});
  endtask

  task automatic idle(input string tag);
    step(tag, 0, 0, 2'b00, 4'd0, 16'h0, 0, 2'b00, 4'd0, 16'h0);
  endtask

  task automatic rd_a(input string tag, input logic [3:0] a, input logic [15:0] want);
    step(tag, 0, 1, 2'b00, a, 16'h0, 0, 2'b00, 4'd0, 16'h0);
`ifdef X_RAMB_DOREG_EN
    idle(tag);
`endif
    chk({tag, ".val"}, DOA, want);
  endtask

  task automatic rd_b(input string tag, input logic [3:0] a, input logic [15:0] want);
    step(tag, 0, 0, 2'b00, 4'd0, 16'h0, 1, 2'b00, a, 16'h0);
`ifdef X_RAMB_DOREG_EN
    idle(tag);
`endif
    chk({tag, ".val"}, DOB, want);
  endtask

  // Clear cycles with user traffic that must be ignored.
  task automatic clear_with_noise(input string tag, input int n);
    for (int i = 0; i < n; i++)
      step($sformatf("%s%0d", tag, i), 0, 1, 2'b11, 4'(i), 16'(i + 16'hDE00),
           1, 2'b11, 4'(15 - i), 16'hC0DE);
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) m_mem[i] = 16'hxxxx;
    m_do1a = 'x; m_do1b = 'x; m_busy = 0; m_coll = 0; m_ptr = 0;
    @(posedge CLK); #1;

    // Power-on reset and first clear.
    step("rst0", 1, 0, 2'b00, 4'd0, 16'h0, 0, 2'b00, 4'd0, 16'h0);
    chk("rst0.srval_a", DOA, 16'hA5A5);
    clear_with_noise("clr0_", DEPTH);
    chk("clr0.busy_done", {15'b0, BUSY}, 16'h0000);

    // Fill with ones, then reset-triggered clear must zero everything.
    for (int a = 0; a < DEPTH; a++)
      step($sformatf("fill%0d", a), 0, 1, 2'b11, 4'(a), 16'hFFFF, 0, 2'b00, 4'd0, 16'h0);
    rd_a("fill.chk", 4'd9, 16'hFFFF);
    step("rst1", 1, 0, 2'b00, 4'd0, 16'h0, 0, 2'b00, 4'd0, 16'h0);
    chk("rst1.srval_a", DOA, 16'hA5A5);
    chk("rst1.busy", {15'b0, BUSY}, 16'h0001);
    clear_with_noise("clr1_", DEPTH);
    for (int a = 0; a < DEPTH; a++) rd_a($sformatf("clr1.rd%0d", a), 4'(a), 16'h0000);

    // Write modes: A write-first, B read-first.
    step("wfA", 0, 1, 2'b11, 4'd3, 16'hBEEF, 0, 2'b00, 4'd0, 16'h0);
`ifdef X_RAMB_DOREG_EN
    idle("wfA.pipe");
`endif
    chk("wfA.val", DOA, 16'hBEEF);
    step("rfB", 0, 0, 2'b00, 4'd0, 16'h0, 1, 2'b11, 4'd3, 16'h1234);
`ifdef X_RAMB_DOREG_EN
    idle("rfB.pipe");
`endif
    chk("rfB.val", DOB, 16'hBEEF);
    rd_b("rfB.reread", 4'd3, 16'h1234);

    // Byte-lane enables.
    step("be.pre", 0, 1, 2'b11, 4'd3, 16'hBEEF, 0, 2'b00, 4'd0, 16'h0);
    step("be.wr", 0, 1, 2'b01, 4'd3, 16'hAA55, 0, 2'b00, 4'd0, 16'h0);
    rd_a("be.rd", 4'd3, 16'hBE55);

    // Collisions: full-word B wins, then disjoint lanes merge.
    step("col.ww", 0, 1, 2'b11, 4'd7, 16'h1111, 1, 2'b11, 4'd7, 16'h2222);
    chk("col.ww.flag", {15'b0, COLLISION}, 16'h0001);
    idle("col.idle");
    chk("col.idle.flag", {15'b0, COLLISION}, 16'h0000);
    rd_a("col.ww.rd", 4'd7, 16'h2222);
    step("col.lane", 0, 1, 2'b10, 4'd7, 16'h1111, 1, 2'b01, 4'd7, 16'h2222);
    rd_b("col.lane.rd", 4'd7, 16'h1122);
    step("col.rw", 0, 1, 2'b00, 4'd7, 16'h0, 1, 2'b11, 4'd7, 16'h3333);
    rd_a("col.rw.rd", 4'd7, 16'h3333);

    // Reset mid-clear restarts the sweep from address 0.
    step("mid.w12", 0, 1, 2'b11, 4'd12, 16'h7777, 0, 2'b00, 4'd0, 16'h0);
    step("mid.rst", 1, 0, 2'b00, 4'd0, 16'h0, 0, 2'b00, 4'd0, 16'h0);
    clear_with_noise("mid.a", 8);
    step("mid.rst2", 1, 0, 2'b00, 4'd0, 16'h0, 0, 2'b00, 4'd0, 16'h0);
    for (int i = 0; i < DEPTH; i++)
      step($sformatf("mid.b%0d", i), 0, 1, 2'b11, 4'd5, 16'hDEAD, 0, 2'b00, 4'd0, 16'h0);
    chk("mid.busy_done", {15'b0, BUSY}, 16'h0000);
    rd_a("mid.rd5", 4'd5, 16'h0000);
    rd_a("mid.rd12", 4'd12, 16'h0000);

    // Read latency: switch port A from one known word to another.
    step("lat.w4", 0, 1, 2'b11, 4'd4, 16'h1357, 0, 2'b00, 4'd0, 16'h0);
    step("lat.w3", 0, 0, 2'b00, 4'd0, 16'h0, 1, 2'b11, 4'd3, 16'hBE55);
    idle("lat.i0");
    step("lat.rd", 0, 1, 2'b00, 4'd3, 16'h0, 0, 2'b00, 4'd0, 16'h0);
`ifdef X_RAMB_DOREG_EN
    chk("lat.edge1", DOA, 16'h1357);
`else
    chk("lat.edge1", DOA, 16'hBE55);
`endif
    idle("lat.i1");
    chk("lat.edge2", DOA, 16'hBE55);

    // Randomized traffic on a narrow address window to provoke conflicts.
    for (int i = 0; i < 400; i++) begin
      step($sformatf("rnd%0d", i), ($urandom_range(0, 59) == 0),
           1'($urandom_range(0, 1)), 2'($urandom), 4'($urandom_range(0, 3)), 16'($urandom),
           1'($urandom_range(0, 1)), 2'($urandom), 4'($urandom_range(0, 3)), 16'($urandom));
    end
    for (int i = 0; i < 24; i++) idle($sformatf("drain%0d", i));
    for (int a = 0; a < 4; a++) rd_a($sformatf("fin.rd%0d", a), 4'(a), m_mem[a]);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
